// File: rtl/root_of_trust.sv
// Root-of-trust bus peripheral: unlock-sequence checker, rate-limited LFSR TRNG, one-time
// PUF key wrapping and a simplified XOR cipher, all behind a 128-word register window.
module root_of_trust #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [31:0] BASE       = 32'h1000_0000,
  parameter logic [31:0] UNLOCK_SEQ = 32'hF0F0_AAAA,
  parameter logic [31:0] PUF_SECRET = 32'hA5C3_5A3C,
  parameter logic [31:0] TRNG_SEED  = 32'hACE1_1234
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] address,
  input  logic             re,
  input  logic             we,
  output logic [WIDTH-1:0] data_o
);

  localparam logic [31:0] LfsrMask = 32'h8020_0003;  // x^32 + x^22 + x^2 + x + 1

  localparam logic [3:0] OpNop     = 4'd0;
  localparam logic [3:0] OpFsm     = 4'd1;
  localparam logic [3:0] OpTrngGen = 4'd2;
  localparam logic [3:0] OpTrngClr = 4'd3;
  localparam logic [3:0] OpPufGen  = 4'd4;
  localparam logic [3:0] OpPufClr  = 4'd5;
  localparam logic [3:0] OpAesRun  = 4'd6;
  localparam logic [3:0] OpAesClr  = 4'd7;
  localparam logic [3:0] OpStatClr = 4'd8;

  typedef enum logic [2:0] {StIdle, StFsm, StTrng, StPuf, StAes} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        match_q, match_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] snap_q [4];
  logic [31:0] snap_d [4];
  logic [31:0] key_q [4];
  logic [31:0] key_d [4];
  logic [31:0] aplain_q [4];
  logic [31:0] aplain_d [4];
  logic [31:0] acyph_q [4];
  logic [31:0] acyph_d [4];
  logic [31:0] pplain_q [32];
  logic [31:0] pplain_d [32];
  logic [31:0] pcyph_q [32];
  logic [31:0] pcyph_d [32];
  logic [31:0] trng_q [4];
  logic [31:0] trng_d [4];
  logic [31:0] fsm_bits_q, fsm_bits_d;
  logic [31:0] op_q, op_d;
  logic        unlocked_q, unlocked_d;
  logic        puf_used_q, puf_used_d;
  logic        lockout_q, lockout_d;
  logic        trng_dirty_q, trng_dirty_d;
  logic        puf_dirty_q, puf_dirty_d;
  logic        aes_dirty_q, aes_dirty_d;
  logic        key_loaded_q, key_loaded_d;
  logic [2:0]  trng_cnt_q, trng_cnt_d;
  logic [1:0]  key_trk_q, key_trk_d;
  logic [31:0] data_o_q, data_o_d;

  // Address decode
  logic [31:0] offset;
  logic [6:0]  off;
  logic        in_win, wr_en, rd_en;
  logic [1:0]  qidx;
  logic [4:0]  pidx;
  logic        is_stat, is_key, is_aplain, is_acyph, is_pplain, is_pcyph, is_trng;
  logic        is_fsm, is_op;

  assign offset = address - BASE;
  assign in_win = (offset < 32'd128);
  assign off    = offset[6:0];
  assign wr_en  = we & in_win;
  assign rd_en  = re & in_win;
  // Every four-word region starts at an offset congruent to 1 mod 4; both PUF arrays at 13 mod 32.
  assign qidx   = off[1:0] - 2'd1;
  assign pidx   = off[4:0] - 5'd13;

  assign is_stat   = (off == 7'd0);
  assign is_key    = (off >= 7'd1)  && (off <= 7'd4);
  assign is_aplain = (off >= 7'd5)  && (off <= 7'd8);
  assign is_acyph  = (off >= 7'd9)  && (off <= 7'd12);
  assign is_pplain = (off >= 7'd13) && (off <= 7'd44);
  assign is_pcyph  = (off >= 7'd45) && (off <= 7'd76);
  assign is_trng   = (off >= 7'd77) && (off <= 7'd80);
  assign is_fsm    = (off == 7'd81);
  assign is_op     = (off == 7'd127);

  // Status and opcode acceptance
  logic        any_busy;
  logic [31:0] status;
  logic [3:0]  opc;
  logic        locked_ok, reject, launch;
  logic [4:0]  bit_idx;
  logic [31:0] lfsr_nxt;
  logic [31:0] rdata;

  assign any_busy = (state_q != StIdle) | lockout_q;
  assign status   = {aes_dirty_q, puf_dirty_q, trng_dirty_q, trng_cnt_q, 20'd0, key_loaded_q,
                     state_q == StAes, state_q == StPuf, state_q == StTrng, state_q == StFsm,
                     any_busy};

  assign opc       = (data_i[WIDTH-1:4] == '0) ? data_i[3:0] : OpNop;
  assign locked_ok = (opc == OpNop) || (opc == OpFsm) || (opc == OpStatClr);
  assign reject    = any_busy || (!unlocked_q && !locked_ok) ||
                     ((opc == OpTrngGen) && (trng_cnt_q == 3'd5)) ||
                     ((opc == OpAesRun) && !key_loaded_q);
  assign launch    = wr_en && is_op && !reject;

  assign bit_idx  = ~cnt_q[4:0];  // MSB-first walk through the unlock pattern
  assign lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrMask : 32'd0);

  always_comb begin
    rdata = '0;
    if (is_stat)        rdata = status;
    else if (is_key)    rdata = key_q[qidx];
    else if (is_acyph)  rdata = acyph_q[qidx];
    else if (is_pcyph)  rdata = pcyph_q[pidx];
    else if (is_trng)   rdata = trng_q[qidx];
    else if (is_fsm)    rdata = fsm_bits_q;
    else if (is_op)     rdata = op_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    match_d      = match_q;
    lfsr_d       = lfsr_q;
    snap_d       = snap_q;
    key_d        = key_q;
    aplain_d     = aplain_q;
    acyph_d      = acyph_q;
    pplain_d     = pplain_q;
    pcyph_d      = pcyph_q;
    trng_d       = trng_q;
    fsm_bits_d   = fsm_bits_q;
    op_d         = op_q;
    unlocked_d   = unlocked_q;
    puf_used_d   = puf_used_q;
    lockout_d    = lockout_q;
    trng_dirty_d = trng_dirty_q;
    puf_dirty_d  = puf_dirty_q;
    aes_dirty_d  = aes_dirty_q;
    key_loaded_d = key_loaded_q;
    trng_cnt_d   = trng_cnt_q;
    key_trk_d    = key_trk_q;
    data_o_d     = rd_en ? rdata : data_o_q;

    // Running engines only touch result registers, so bus writes below never collide with them.
    unique case (state_q)
      StIdle: ;
      StFsm: begin
        match_d = match_q & (fsm_bits_q[bit_idx] == UNLOCK_SEQ[bit_idx]);
        if (cnt_q == 8'd31) begin
          unlocked_d = match_d;
          state_d    = StIdle;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StTrng: begin
        lfsr_d    = lfsr_nxt;
        snap_d[0] = lfsr_nxt;
        for (int i = 1; i < 4; i++) snap_d[i] = snap_q[i-1];
        if (cnt_q == 8'd63) begin
          trng_d       = snap_d;
          trng_cnt_d   = trng_cnt_q + 3'd1;
          trng_dirty_d = 1'b1;
          state_d      = StIdle;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StPuf: begin
        if (cnt_q == 8'd255) begin
          for (int i = 0; i < 32; i++) pcyph_d[i] = pplain_q[i] ^ PUF_SECRET ^ 32'(i);
          puf_dirty_d = 1'b1;
          puf_used_d  = 1'b1;
          state_d     = StIdle;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StAes: begin
        if (cnt_q == 8'd9) begin
          for (int i = 0; i < 4; i++) acyph_d[i] = aplain_q[i] ^ key_q[i];
          aes_dirty_d = 1'b1;
          state_d     = StIdle;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_en) begin
      if (is_key) begin
        key_d[qidx] = data_i;
        // Key counts as loaded only after offsets 1,2,3,4 are written back-to-back.
        if (qidx == key_trk_q) begin
          if (key_trk_q == 2'd3) begin
            key_loaded_d = 1'b1;
            key_trk_d    = 2'd0;
          end else begin
            key_trk_d = key_trk_q + 2'd1;
          end
        end else begin
          key_trk_d = (qidx == 2'd0) ? 2'd1 : 2'd0;
        end
      end
      if (is_aplain) aplain_d[qidx] = data_i;
      if (is_pplain) pplain_d[pidx] = data_i;
      if (is_fsm)    fsm_bits_d     = data_i;
      if (is_op)     op_d           = data_i;
    end

    if (launch) begin
      case (opc)
        OpFsm: begin
          state_d = StFsm;
          cnt_d   = '0;
          match_d = 1'b1;
        end
        OpTrngGen: begin
          state_d = StTrng;
          cnt_d   = '0;
        end
        OpTrngClr: for (int i = 0; i < 4; i++) trng_d[i] = '0;
        OpPufGen: begin
          if (puf_used_q) begin
            lockout_d = 1'b1;
          end else begin
            state_d = StPuf;
            cnt_d   = '0;
          end
        end
        OpPufClr: for (int i = 0; i < 32; i++) pplain_d[i] = '0;
        OpAesRun: begin
          state_d = StAes;
          cnt_d   = '0;
        end
        OpAesClr: begin
          for (int i = 0; i < 4; i++) begin
            key_d[i]    = '0;
            aplain_d[i] = '0;
            acyph_d[i]  = '0;
          end
        end
        OpStatClr: begin
          trng_cnt_d   = '0;
          trng_dirty_d = 1'b0;
          puf_dirty_d  = 1'b0;
          aes_dirty_d  = 1'b0;
          key_loaded_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      match_q      <= 1'b0;
      lfsr_q       <= TRNG_SEED;
      for (int i = 0; i < 4; i++) begin
        snap_q[i]   <= '0;
        key_q[i]    <= '0;
        aplain_q[i] <= '0;
        acyph_q[i]  <= '0;
        trng_q[i]   <= '0;
      end
      for (int i = 0; i < 32; i++) begin
        pplain_q[i] <= '0;
        pcyph_q[i]  <= '0;
      end
      fsm_bits_q   <= '0;
      op_q         <= '0;
      unlocked_q   <= 1'b0;
      puf_used_q   <= 1'b0;
      lockout_q    <= 1'b0;
      trng_dirty_q <= 1'b0;
      puf_dirty_q  <= 1'b0;
      aes_dirty_q  <= 1'b0;
      key_loaded_q <= 1'b0;
      trng_cnt_q   <= '0;
      key_trk_q    <= '0;
      data_o_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      match_q      <= match_d;
      lfsr_q       <= lfsr_d;
      snap_q       <= snap_d;
      key_q        <= key_d;
      aplain_q     <= aplain_d;
      acyph_q      <= acyph_d;
      pplain_q     <= pplain_d;
      pcyph_q      <= pcyph_d;
      trng_q       <= trng_d;
      fsm_bits_q   <= fsm_bits_d;
      op_q         <= op_d;
      unlocked_q   <= unlocked_d;
      puf_used_q   <= puf_used_d;
      lockout_q    <= lockout_d;
      trng_dirty_q <= trng_dirty_d;
      puf_dirty_q  <= puf_dirty_d;
      aes_dirty_q  <= aes_dirty_d;
      key_loaded_q <= key_loaded_d;
      trng_cnt_q   <= trng_cnt_d;
      key_trk_q    <= key_trk_d;
      data_o_q     <= data_o_d;
    end
  end

  assign data_o = data_o_q;

endmodule

// File: tb/tb_root_of_trust.sv
// Bench for root_of_trust: directed scenarios plus randomized bus traffic, every read compared
// against a transaction-level reference model that schedules operation completions by cycle.
module tb_root_of_trust;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] UNLOCK = 32'hF0F0_AAAA;
  localparam logic [31:0] SECRET = 32'hA5C3_5A3C;
  localparam logic [31:0] SEED   = 32'hACE1_1234;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] address = '0;
  logic [31:0] data_o;

  always #5 clk = ~clk;

  root_of_trust #(
    .WIDTH(32), .BASE(BASE), .UNLOCK_SEQ(UNLOCK), .PUF_SECRET(SECRET), .TRNG_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .address(address), .re(re), .we(we),
    .data_o(data_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_key [4];
  logic [31:0] m_ap [4];
  logic [31:0] m_ac [4];
  logic [31:0] m_pp [32];
  logic [31:0] m_pc [32];
  logic [31:0] m_trng [4];
  logic [31:0] m_fsm, m_op, m_lfsr, m_do;
  bit          m_unlock, m_puf_used, m_lockout, m_tdirty, m_pdirty, m_adirty, m_kload;
  int          m_tcnt;
  int          m_run;      // 0 none, 1 unlock check, 2 trng, 3 puf, 4 aes
  longint      m_done_at;
  longint      cyc = 0;
  int          m_khist[$];

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_key[i] = '0; m_ap[i] = '0; m_ac[i] = '0; m_trng[i] = '0;
    end
    for (int i = 0; i < 32; i++) begin
      m_pp[i] = '0; m_pc[i] = '0;
    end
    m_fsm = '0; m_op = '0; m_lfsr = SEED; m_do = '0;
    m_unlock = 0; m_puf_used = 0; m_lockout = 0;
    m_tdirty = 0; m_pdirty = 0; m_adirty = 0; m_kload = 0;
    m_tcnt = 0; m_run = 0; m_done_at = 0;
    m_khist.delete();
  endtask

  function automatic logic [31:0] m_status();
    return {m_adirty, m_pdirty, m_tdirty, 3'(m_tcnt), 20'd0, m_kload,
            m_run == 4, m_run == 3, m_run == 2, m_run == 1, (m_run != 0) || m_lockout};
  endfunction

  function automatic logic [31:0] m_read(input int o);
    if (o == 0) return m_status();
    if (o >= 1 && o <= 4) return m_key[o-1];
    if (o >= 9 && o <= 12) return m_ac[o-9];
    if (o >= 45 && o <= 76) return m_pc[o-45];
    if (o >= 77 && o <= 80) return m_trng[o-77];
    if (o == 81) return m_fsm;
    if (o == 127) return m_op;
    return '0;
  endfunction

  task automatic m_edge(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] o32, s;
    int o, opc;
    bit busy_pre, rej;
    o32 = a - BASE;
    o = int'(o32[6:0]);
    if (r && o32 < 128) m_do = m_read(o);
    busy_pre = (m_run != 0);
    if (m_run != 0 && cyc == m_done_at) begin
      case (m_run)
        1: m_unlock = (m_fsm == UNLOCK);
        2: begin
          s = m_lfsr;
          for (int k = 1; k <= 64; k++) begin
            s = lfsr_next(s);
            if (k > 60) m_trng[64-k] = s;
          end
          m_lfsr = s; m_tcnt++; m_tdirty = 1;
        end
        3: begin
          for (int i = 0; i < 32; i++) m_pc[i] = m_pp[i] ^ SECRET ^ i;
          m_pdirty = 1; m_puf_used = 1;
        end
        default: begin
          for (int i = 0; i < 4; i++) m_ac[i] = m_ap[i] ^ m_key[i];
          m_adirty = 1;
        end
      endcase
      m_run = 0;
    end
    if (w && o32 < 128) begin
      if (o >= 1 && o <= 4) begin
        m_key[o-1] = d;
        m_khist.push_back(o);
        if (m_khist.size() > 4) void'(m_khist.pop_front());
        if (m_khist.size() == 4 && m_khist[0] == 1 && m_khist[1] == 2 && m_khist[2] == 3 &&
            m_khist[3] == 4) m_kload = 1;
      end
      if (o >= 5 && o <= 8) m_ap[o-5] = d;
      if (o >= 13 && o <= 44) m_pp[o-13] = d;
      if (o == 81) m_fsm = d;
      if (o == 127) begin
        m_op = d;
        opc = (d[31:4] == 0) ? int'(d[3:0]) : 0;
        rej = busy_pre || m_lockout || (!m_unlock && !(opc == 0 || opc == 1 || opc == 8)) ||
              (opc == 2 && m_tcnt == 5) || (opc == 6 && !m_kload);
        if (!rej) begin
          case (opc)
            1: begin m_run = 1; m_done_at = cyc + 32; end
            2: begin m_run = 2; m_done_at = cyc + 64; end
            3: for (int i = 0; i < 4; i++) m_trng[i] = '0;
            4: begin
              if (m_puf_used) m_lockout = 1;
              else begin m_run = 3; m_done_at = cyc + 256; end
            end
            5: for (int i = 0; i < 32; i++) m_pp[i] = '0;
            6: begin m_run = 4; m_done_at = cyc + 10; end
            7: for (int i = 0; i < 4; i++) begin
              m_key[i] = '0; m_ap[i] = '0; m_ac[i] = '0;
            end
            8: begin m_tcnt = 0; m_tdirty = 0; m_pdirty = 0; m_adirty = 0; m_kload = 0; end
            default: ;
          endcase
        end
      end
    end
    cyc++;
  endtask

  // One bus cycle: drive, clock, advance model, compare any read.
  task automatic bus(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    we = w; re = r; address = a; data_i = d;
    @(posedge clk);
    m_edge(w, r, a, d);
    #1;
    if (r) check_eq($sformatf("model_rd_a%h", a), data_o, m_do);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; we = 1'b0; re = 1'b0;
    @(posedge clk);
    m_reset();
    #1;
    rst_n = 1'b1;
    check_eq("rst_data_o", data_o, 32'h0);
  endtask

  task automatic wr_off(input int o, input logic [31:0] d);
    bus(1'b1, 1'b0, BASE + 32'(o), d);
  endtask

  task automatic op(input logic [31:0] code);
    wr_off(127, code);
  endtask

  task automatic rd_off(input int o, output logic [31:0] v);
    bus(1'b0, 1'b1, BASE + 32'(o), 32'h0);
    v = data_o;
  endtask

  task automatic wait_idle(input int budget, input string tag, output logic [31:0] v);
    int n;
    n = 0;
    v = 32'h1;
    while (v[0] && n < budget) begin
      rd_off(0, v);
      n++;
    end
    check_eq(tag, {31'b0, v[0]}, 32'h0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  logic [31:0] v, t0, a, d, code;
  int unsigned r, o;

  initial begin
    do_reset();
    rd_off(0, v);
    check_eq("rst_status", v, 32'h0);

    // Wrong unlock pattern: runs, fails, and leaves the block locked.
    wr_off(81, 32'hFAAA_AAAA);
    op(1);
    rd_off(0, v);
    check_eq("fsm_busy_lsb", v[5:0], 6'b000011);
    wait_idle(40, "fsm_done", v);
    check_eq("fsm_fail_status", v, 32'h0);
    op(2);
    wait_idle(5, "trng_locked_idle", v);
    check_eq("trng_locked_cnt", v[28:26], 3'd0);

    // Fill the window, then read it back.
    for (int i = 127; i >= 0; i--) wr_off(i, 32'h1234_5678);
    for (int i = 0; i < 128; i++) begin
      rd_off(i, v);
      if ((i >= 1 && i <= 4) || i == 81 || i == 127) check_eq($sformatf("rb_%0d", i), v,
                                                              32'h1234_5678);
      else check_eq($sformatf("rb_differ_%0d", i), {31'b0, v == 32'h1234_5678}, 32'h0);
    end

    // Unlock, then a burst of ops while PUF is busy.
    wr_off(81, UNLOCK);
    op(1);
    wait_idle(40, "unlock_done", v);
    op(4); op(1); op(2); op(5); op(6); op(0);
    rd_off(0, v);
    check_eq("puf_busy_lsb", v[5:0], 6'b001001);
    check_eq("puf_busy_msb", v[31:26], 6'b000000);
    wait_idle(270, "puf_done", v);
    check_eq("puf_done_msb", v[31:26], 6'b010000);
    rd_off(45, v);
    check_eq("puf_cyph0", v, 32'h1234_5678 ^ SECRET);
    rd_off(76, v);
    check_eq("puf_cyph31", v, 32'h1234_5678 ^ SECRET ^ 32'd31);

    // TRNG generation limit.
    for (int k = 0; k < 5; k++) begin
      op(2);
      wait_idle(70, $sformatf("trng_gen%0d", k), v);
    end
    rd_off(0, v);
    check_eq("trng5_msb", v[31:26], 6'b011101);
    op(2);
    wait_idle(3, "trng6_rej_idle", v);
    check_eq("trng6_msb", v[31:26], 6'b011101);

    // Key-load tracking and clear opcodes.
    wr_off(1, 32'h11); wr_off(3, 32'h33); wr_off(4, 32'h44); wr_off(2, 32'h22);
    rd_off(0, v);
    check_eq("key_ooo_bit5", v[5], 1'b0);
    wr_off(1, 32'h11); wr_off(2, 32'h22); wr_off(3, 32'h33); wr_off(4, 32'h44);
    rd_off(0, v);
    check_eq("key_inorder_bit5", v[5], 1'b1);
    op(7);
    for (int i = 1; i <= 4; i++) begin
      rd_off(i, v);
      check_eq($sformatf("aes_clr_key%0d", i), v, 32'h0);
    end
    rd_off(0, v);
    check_eq("aes_clr_bit5", v[5], 1'b1);
    op(5);
    rd_off(45, v);
    check_eq("puf_clr_keeps_cyph", v, 32'h1234_5678 ^ SECRET);
    rd_off(77, t0);
    check_eq("trng_word_nonzero", {31'b0, t0 == 32'h0}, 32'h0);
    op(3);
    rd_off(77, v);
    check_eq("trng_clr_word", v, 32'h0);
    op(8);
    rd_off(0, v);
    check_eq("stat_clr", v, 32'h0);
    bus(1'b1, 1'b0, BASE + 32'd128, 32'd4);
    bus(1'b1, 1'b0, BASE - 32'd1, 32'd4);
    bus(1'b1, 1'b0, 32'h0000_007F, 32'd4);
    rd_off(0, v);
    check_eq("outside_writes_status", v, 32'h0);
    rd_off(127, v);
    check_eq("outside_writes_opreg", v, 32'd8);

    // Key writes during a TRNG run, then PUF reuse lockout.
    op(2);
    for (int i = 1; i <= 4; i++) wr_off(i, 32'hFFFF_FFFF);
    wait_idle(70, "trng_keywr_done", v);
    rd_off(1, v);
    check_eq("key_during_busy", v, 32'hFFFF_FFFF);
    rd_off(0, v);
    check_eq("trng_keywr_msb", v[31:26], 6'b001001);
    check_eq("trng_keywr_lsb", v[5:0], 6'b100000);
    op(4);
    rd_off(0, v);
    check_eq("lockout_lsb", v[5:0], 6'b100001);
    op(8);
    for (int i = 0; i < 20; i++) bus(1'b0, 1'b0, 32'h0, 32'h0);
    rd_off(0, v);
    check_eq("lockout_sticky_lsb", v[5:0], 6'b100001);
    check_eq("lockout_sticky_msb", v[31:26], 6'b001001);
    wr_off(81, 32'h55);
    rd_off(81, v);
    check_eq("lockout_datawr", v, 32'h55);
    do_reset();
    rd_off(0, v);
    check_eq("rst_exits_lockout", v, 32'h0);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      wr_off(81, UNLOCK);
      op(1);
      wait_idle(40, "rnd_unlock", v);
      for (int n = 0; n < 500; n++) begin
        r = $urandom_range(0, 99);
        o = $urandom_range(0, 127);
        a = BASE + o;
        d = $urandom();
        if ($urandom_range(0, 19) == 0) a = $urandom();
        if (a == BASE + 32'd81 && m_run == 1) a = BASE + 32'd82;
        if (r < 35) bus(1'b0, 1'b1, a, 32'h0);
        else if (r < 65) bus(1'b1, 1'b0, a, d);
        else if (r < 80) bus(1'b1, 1'b1, a, d);
        else if (r < 92) begin
          code = $urandom_range(0, 9);
          if (code == 32'd4 && $urandom_range(0, 3) != 0) code = 32'd2;
          if ($urandom_range(0, 7) == 0) code = code | 32'h100;
          bus(1'b1, 1'($urandom_range(0, 1)), BASE + 32'd127, code);
        end else begin
          for (int k = 1; k <= 4; k++) bus(1'b1, 1'b0, BASE + 32'(k), $urandom());
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
